// File: rtl/led_pkg.sv
// Shared constants and types for the LED PWM controller and the breathing-pattern generator.
// Contents: default timebase parameters, channel count and channel-index type.
package led_pkg;

    localparam int unsigned PRESC  = 24;    // clk cycles per PWM tick (1 us at 24 MHz)
    localparam int unsigned PERIOD = 1000;  // ticks per PWM period (1 ms)
    localparam int unsigned DW     = 10;    // duty width, 2**DW > PERIOD
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CH_W   = 2;

    typedef logic [CH_W-1:0] ch_idx_t;

    // Index 3 is accepted on the bus but maps to no channel.
    localparam ch_idx_t CH_RSVD = CH_W'(3);

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// Duty-write channel into the LED PWM controller.
// Signals: duty_valid/duty_ready handshake, duty_ch target channel, duty_val on-time in ticks.
// master: upstream writer; slave: led_pwm_ctrl.
interface led_pwm_ctrl_if #(
    parameter int unsigned DW = led_pkg::DW
);
    import led_pkg::*;

    logic          duty_valid;
    logic          duty_ready;
    ch_idx_t       duty_ch;
    logic [DW-1:0] duty_val;

    modport master (
        output duty_valid,
        output duty_ch,
        output duty_val,
        input  duty_ready
    );

    modport slave (
        input  duty_valid,
        input  duty_ch,
        input  duty_val,
        output duty_ready
    );

endinterface

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler (pre) and period counter (per) with tick/boundary detection.
// Ports: clk, rst_n (async active-low), run (count enable; low holds both counters at 0),
//        per (registered period position), boundary_c (last clk of the last tick of a period).
module pwm_timebase #(
    parameter int unsigned PRESC  = led_pkg::PRESC,
    parameter int unsigned PERIOD = led_pkg::PERIOD,
    parameter int unsigned DW     = led_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    output logic [DW-1:0] per,
    output logic          boundary_c
);

    localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0] pre;
    logic          tick_c;

    assign tick_c     = run && (pre == PW'(PRESC - 1));
    assign boundary_c = tick_c && (per == DW'(PERIOD - 1));

    // Counters clear whenever run drops so a restart always begins at pre=0, per=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            per <= '0;
        end else if (!run) begin
            pre <= '0;
            per <= '0;
        end else begin
            pre <= tick_c ? '0 : pre + PW'(1);
            if (tick_c) begin
                per <= boundary_c ? '0 : per + DW'(1);
            end
        end
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Three-channel LED PWM controller with shadow/active duty registers.
// Ports: clk, rst_n (async assert, synchronised release), en (global enable),
//        duty_if (slave duty-write channel), led[2:0] (registered PWM outputs),
//        period_tick (registered one-cycle pulse after each period boundary).
module led_pwm_ctrl #(
    parameter int unsigned PRESC  = led_pkg::PRESC,
    parameter int unsigned PERIOD = led_pkg::PERIOD,
    parameter int unsigned DW     = led_pkg::DW
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    led_pwm_ctrl_if.slave               duty_if,
    output logic [led_pkg::NUM_CH-1:0]  led,
    output logic                        period_tick
);

    import led_pkg::*;

    if (2**DW <= PERIOD) begin : g_dw_check
        $error("led_pwm_ctrl: DW too narrow to hold PERIOD");
    end

    logic [1:0]    rst_sync;
    logic          run_c;
    logic          wr_c;
    logic          boundary_c;
    logic [DW-1:0] per;
    logic [DW-1:0] shadow [NUM_CH];
    logic [DW-1:0] active [NUM_CH];

    // Two-flop release synchroniser; counting starts only once it has propagated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run_c              = en && rst_sync[1];
    assign duty_if.duty_ready = en;
    assign wr_c               = duty_if.duty_valid && en;

    pwm_timebase #(
        .PRESC  (PRESC),
        .PERIOD (PERIOD),
        .DW     (DW)
    ) u_timebase (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run_c),
        .per        (per),
        .boundary_c (boundary_c)
    );

    // Active copies the pre-write shadow, so a write on the boundary edge lands one period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (boundary_c) begin
                    active[i] <= shadow[i];
                end
                if (wr_c && (duty_if.duty_ch == CH_W'(i))) begin
                    shadow[i] <= duty_if.duty_val;
                end
            end
        end
    end

    // Unsigned compare saturates naturally: active=0 never on, active>=PERIOD always on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led         <= '0;
            period_tick <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                led[i] <= en && (per < active[i]);
            end
            period_tick <= boundary_c;
        end
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl with PRESC=2, PERIOD=10, DW=4.
module tb_led_pwm_ctrl;

    localparam int unsigned TP  = 2;
    localparam int unsigned TN  = 10;
    localparam int unsigned TW  = 4;
    localparam int          LEN = TP * TN;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic [2:0] led;
    logic       period_tick;

    led_pwm_ctrl_if #(.DW(TW)) dif ();

    led_pwm_ctrl #(
        .PRESC  (TP),
        .PERIOD (TN),
        .DW     (TW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .duty_if     (dif.slave),
        .led         (led),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: period position derived from the count of running cycles.
    logic [TW-1:0] m_shadow [3];
    logic [TW-1:0] m_active [3];
    int            m_cnt;
    int            m_sync;
    int            m_pos;
    int            m_per;
    bit            m_run;
    bit            m_bnd;
    logic [2:0]    m_led;
    logic          m_pt;
    bit            m_on = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
            m_cnt  = 0;
            m_sync = 0;
            m_led  = '0;
            m_pt   = 1'b0;
        end else begin
            m_run = en && (m_sync == 2);
            m_pos = m_cnt % LEN;
            m_per = m_pos / TP;
            m_bnd = m_run && (m_pos == LEN - 1);
            for (int i = 0; i < 3; i++) begin
                m_led[i] = en && (m_per < int'(m_active[i]));
            end
            m_pt = m_bnd;
            if (m_bnd) begin
                for (int i = 0; i < 3; i++) m_active[i] = m_shadow[i];
            end
            if (en && dif.duty_valid) begin
                for (int i = 0; i < 3; i++) begin
                    if (int'(dif.duty_ch) == i) m_shadow[i] = dif.duty_val;
                end
            end
            m_cnt = m_run ? m_cnt + 1 : 0;
            if (m_sync < 2) m_sync = m_sync + 1;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("model_led", 32'(led), 32'(m_led));
            check("model_period_tick", 32'(period_tick), 32'(m_pt));
            check("model_duty_ready", 32'(dif.duty_ready), 32'(en));
        end
    end

    task automatic wait_pt(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 100);
        check(name, 32'(period_tick), 32'd1);
    endtask

    task automatic count_on(input int ch, input int cycles, output int on);
        on = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (led[ch] === 1'b1) on++;
        end
    endtask

    task automatic write_now(input int ch, input int val);
        @(posedge clk);
        #1;
        dif.duty_valid = 1'b1;
        dif.duty_ch    = 2'(ch);
        dif.duty_val   = TW'(val);
        @(posedge clk);
        #1;
        dif.duty_valid = 1'b0;
    endtask

    // Counts edges from release (first edge after release is edge 0) until period_tick is seen.
    task automatic first_pulse(input string name);
        int edges;
        edges = -1;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!period_tick && edges < 100);
        check(name, 32'(edges), 32'd21);
    endtask

    typedef struct {
        int ch;
        int val;
        int on;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int on;

        tbl[0] = '{0, 3, 6};
        tbl[1] = '{1, 10, 20};
        tbl[2] = '{2, 15, 20};
        tbl[3] = '{1, 0, 0};
        tbl[4] = '{2, 1, 2};
        tbl[5] = '{0, 9, 18};

        dif.duty_valid = 1'b0;
        dif.duty_ch    = '0;
        dif.duty_val   = '0;
        en             = 1'b1;

        #2 rst_n = 1'b0;
        m_on = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_led", 32'(led), 32'd0);
        check("reset_period_tick", 32'(period_tick), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle timebase: first pulse 21 edges after release, then every 20.
        first_pulse("first_pulse_edge");
        wait_pt("pt_gap1_seen", n);
        check("pt_gap1", 32'(n), 32'(LEN));
        wait_pt("pt_gap2_seen", n);
        check("pt_gap2", 32'(n), 32'(LEN));
        check("idle_led", 32'(led), 32'd0);

        // Mid-period writes take effect from the next boundary.
        for (int k = 0; k < 6; k++) begin
            wait_pt("tbl_sync", n);
            repeat (4) @(posedge clk);
            write_now(tbl[k].ch, tbl[k].val);
            wait_pt("tbl_load", n);
            count_on(tbl[k].ch, LEN, on);
            check($sformatf("tbl%0d_on_ch%0d_val%0d", k, tbl[k].ch, tbl[k].val), 32'(on), 32'(tbl[k].on));
        end

        // Write on the exact boundary edge: old shadow used first, new one a period later.
        wait_pt("bw_sync", n);
        repeat (4) @(posedge clk);
        write_now(0, 2);
        wait_pt("bw_load2", n);
        repeat (19) @(posedge clk);
        #1;
        dif.duty_valid = 1'b1;
        dif.duty_ch    = 2'd0;
        dif.duty_val   = TW'(5);
        @(posedge clk);
        #1;
        dif.duty_valid = 1'b0;
        @(negedge clk);
        check("bw_pt_on_write_edge", 32'(period_tick), 32'd1);
        count_on(0, LEN, on);
        check("bw_first_period_on", 32'(on), 32'd4);
        count_on(0, LEN, on);
        check("bw_second_period_on", 32'(on), 32'd10);

        // Enable dropped for 7 cycles with a refused write attempt.
        repeat (5) @(posedge clk);
        #1;
        en             = 1'b0;
        dif.duty_valid = 1'b1;
        dif.duty_ch    = 2'd0;
        dif.duty_val   = TW'(1);
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
            check("en_low_led", 32'(led), 32'd0);
            check("en_low_ready", 32'(dif.duty_ready), 32'd0);
        end
        en             = 1'b1;
        dif.duty_valid = 1'b0;
        on = 0;
        for (int j = 0; j < LEN; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (led[0] === 1'b1) on++;
            if (j == LEN - 1) check("en_restart_pt", 32'(period_tick), 32'd1);
        end
        check("en_restart_on", 32'(on), 32'd10);
        check("en_restart_ready", 32'(dif.duty_ready), 32'd1);
        count_on(0, LEN, on);
        check("en_refused_write_on", 32'(on), 32'd10);

        // Asynchronous reset mid-period with ch0=8 active.
        repeat (4) @(posedge clk);
        write_now(0, 8);
        wait_pt("rst_load8", n);
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_led", 32'(led), 32'd0);
        check("rst_async_pt", 32'(period_tick), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        first_pulse("rst_first_pulse_edge");
        count_on(0, LEN, on);
        check("rst_ch0_cleared_on", 32'(on), 32'd0);
        repeat (4) @(posedge clk);
        write_now(0, 8);
        wait_pt("rst_reload8", n);
        count_on(0, LEN, on);
        check("rst_ch0_rewritten_on", 32'(on), 32'd16);

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 39) == 0) en = ~en;
            dif.duty_valid = ($urandom_range(0, 3) == 0);
            dif.duty_ch    = 2'($urandom_range(0, 3));
            dif.duty_val   = TW'($urandom_range(0, 15));
        end
        @(posedge clk);
        #1;
        en             = 1'b1;
        dif.duty_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pwm_ctrl.md
LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Interface
REQ-001 Parameter PRESC, default 24: clk cycles per PWM tick (1 us at 24 MHz).
REQ-002 Parameter PERIOD, default 1000: ticks per PWM period (1 ms).
REQ-003 Parameter DW, default 10: duty width in bits; SHALL satisfy 2**DW > PERIOD.
REQ-004 Port clk  input  1: single system clock, all logic on rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 Port en  input  1: global enable; low forces LEDs off and holds the timebase.
REQ-007 Port duty_valid  input  1: upstream duty write request.
REQ-008 Port duty_ready  output  1: block can accept a duty write.
REQ-009 Port duty_ch  input  2: target channel, 0..2 valid, 3 reserved.
REQ-010 Port duty_val  input  DW: requested on-time in ticks per period.
REQ-011 Port led  output  3: PWM outputs, 1 = LED on.
REQ-012 Port period_tick  output  1: one-cycle pulse at each period boundary.

Function
REQ-013 duty_ready SHALL equal en, combinationally; a write is accepted on a cycle where duty_valid && duty_ready.
REQ-014 An accepted write SHALL load shadow[duty_ch] <= duty_val on that edge; duty_ch==3 is accepted and discarded.
REQ-015 Prescaler pre SHALL count 0..PRESC-1 while en=1 and wrap to 0; tick = en && pre==PRESC-1.
REQ-016 Period counter per SHALL increment on tick and wrap PERIOD-1 -> 0; boundary = tick && per==PERIOD-1.
REQ-017 On boundary, active[i] <= shadow[i] for all i; duty changes SHALL take effect only at a boundary, never mid-period.
REQ-018 Write and boundary on the same cycle: active gets the pre-write shadow; the new value goes to shadow and applies one period later.
REQ-019 led[i] SHALL be registered as en && (per < active[i]), giving one-cycle latency from counter to pin.
REQ-020 active==0: led[i] constant 0; active>=PERIOD (saturating, including PERIOD..2**DW-1): led[i] constant 1.
REQ-021 period_tick SHALL be registered, high for exactly the one cycle after boundary.
REQ-022 en falling: on the next edge pre and per go to 0 and led goes to 000; shadow and active are retained; writes are refused (duty_ready=0).
REQ-023 en rising: counting restarts from pre=0, per=0; the first period uses the retained active values.
REQ-024 Comparison SHALL be unsigned DW-bit with no truncation; per width is DW.

Reset
REQ-025 rst_n low SHALL asynchronously clear pre, per, all shadow and active, led=000, and period_tick=0.
REQ-026 Reset release SHALL be synchronised (two-flop) so the first counting edge is glitch-free; an asserted rst_n mid-period SHALL abort the period immediately.
REQ-027 After release with en=1, the first boundary SHALL occur PRESC*PERIOD cycles after counting starts.

Structure
REQ-028 Package led_pkg SHALL hold PRESC, PERIOD, DW, NUM_CH=3 and the channel-index type shared with the breathing-pattern generator.
REQ-029 Sub-module pwm_timebase (pre/per counters, tick, boundary, en handling) SHALL be instantiated once; comparators and shadow/active registers stay in led_pwm_ctrl.

Verification (PRESC=2, PERIOD=10, DW=4 unless noted)
REQ-030 Reset, en=1, no writes -> led=000 forever; period_tick every 20 cycles; first pulse 21 cycles after release.
REQ-031 Write ch0=3 mid-period -> led[0] unchanged until the boundary, then high for 6 cycles and low for 14 in every period.
REQ-032 Write ch1=10 and ch2=15 -> after the boundary led[1] and led[2] stay at constant 1; write ch1=0 -> constant 0 from the next boundary.
REQ-033 Write ch0=5 on the exact boundary cycle while shadow=2 -> next period on 4 cycles, the period after on 10 cycles.
REQ-034 en dropped mid-period, held for 7 cycles, then restored -> led=000 and duty_ready=0 while low; the period restarts at per=0 with the prior duties.
REQ-035 rst_n pulsed low mid-period with ch0=8 active -> led=000 immediately; after release ch0 stays off until it is rewritten.
